// File: rtl/mario_horizontal_mover.sv
// mario_horizontal_mover: pixel-stepped horizontal motion with accel/friction and tile/screen collision
module mario_horizontal_mover #(
  parameter int SPRITE_WIDTH  = 42,
  parameter int SPRITE_HEIGHT = 42,
  parameter int BLOCK_WIDTH   = 40,
  parameter int SCREEN_WIDTH  = 640,
  parameter int MAP_ROWS      = 12,
  parameter int MAP_COLS      = 17,
  parameter int BLK           = 2,
  parameter int START_X       = 100,
  parameter int MAX_SPEED     = 4,
  parameter int ACCEL_TICKS   = 4
)(
  input  logic                                 movement_clock,
  input  logic                                 reset,
  input  logic                                 tick,
  input  logic                                 left,
  input  logic                                 right,
  input  logic [7:0]                           background [MAP_ROWS][MAP_COLS],
  input  logic signed [31:0]                   mario_y,
  output logic signed [31:0]                   mario_x,
  output logic signed [$clog2(MAX_SPEED)+1:0]  velocity,
  output logic                                 facing_left,
  output logic                                 busy,
  output logic                                 blocked
);
  localparam int VW = $clog2(MAX_SPEED) + 2;
  localparam int AW = ACCEL_TICKS > 1 ? $clog2(ACCEL_TICKS) : 1;
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] STEP = 1'b1;
  localparam logic signed [VW-1:0] V_MAX = VW'(MAX_SPEED);
  localparam logic signed [VW-1:0] V_ONE = VW'(1);
  localparam logic [VW-1:0] R_ONE = VW'(1);
  localparam logic [AW-1:0] ACC_LAST = AW'(ACCEL_TICKS - 1);
  localparam logic [AW-1:0] ACC_ONE = AW'(1);
  localparam logic [7:0] BLK_CODE = 8'(BLK);
  localparam logic signed [31:0] X0 = 32'(START_X);

  logic [0:0]              state;
  logic                    pending, dir_left, tile_hit, collide;
  logic [AW-1:0]           accel_count, eff_count, next_count;
  logic signed [1:0]       intent, prev_intent;
  logic signed [VW-1:0]    target, v_new;
  logic [VW-1:0]           v_abs, remaining;
  logic signed [31:0]      nx, lead_col, row_top, row_bot;

  always_comb begin
    intent = (right && !left) ? 2'sd1 : (left && !right) ? -2'sd1 : 2'sd0;
    target = intent == 2'sd1 ? V_MAX : intent == -2'sd1 ? -V_MAX : '0;
    eff_count = intent != prev_intent ? '0 : accel_count;
    v_new = eff_count != '0 ? velocity :
            velocity < target ? velocity + V_ONE :
            velocity > target ? velocity - V_ONE : velocity;
    next_count = eff_count == ACC_LAST ? '0 : eff_count + ACC_ONE;
    v_abs = v_new[VW-1] ? -v_new : v_new;
    nx = dir_left ? mario_x - 32'sd1 : mario_x + 32'sd1;
    // only the column the sprite is moving into can newly overlap a tile
    lead_col = dir_left ? nx / BLOCK_WIDTH : (nx + SPRITE_WIDTH - 1) / BLOCK_WIDTH;
    row_top = mario_y / BLOCK_WIDTH;
    row_bot = (mario_y + SPRITE_HEIGHT - 1) / BLOCK_WIDTH;
    tile_hit = 1'b0;
    for (int r = 0; r < MAP_ROWS; r++)
      for (int c = 0; c < MAP_COLS; c++)
        tile_hit |= (row_top == r || row_bot == r) && lead_col == c && background[r][c] == BLK_CODE;
    collide = tile_hit || nx < 0 || nx + SPRITE_WIDTH > SCREEN_WIDTH;
  end

  always_ff @(posedge movement_clock or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      mario_x     <= X0;
      velocity    <= '0;
      facing_left <= 1'b0;
      blocked     <= 1'b0;
      accel_count <= '0;
      pending     <= 1'b0;
      prev_intent <= '0;
      remaining   <= '0;
      dir_left    <= 1'b0;
    end else if (state == IDLE) begin
      if (tick || pending) begin
        pending     <= 1'b0;
        blocked     <= 1'b0;
        velocity    <= v_new;
        accel_count <= next_count;
        prev_intent <= intent;
        if (intent != 2'sd0) facing_left <= intent[1];
        remaining   <= v_abs;
        dir_left    <= v_new[VW-1];
        if (v_new != '0) state <= STEP;
      end
    end else begin
      pending <= pending | tick;
      if (collide) begin
        velocity    <= '0;
        accel_count <= '0;
        blocked     <= 1'b1;
        state       <= IDLE;
      end else begin
        mario_x   <= nx;
        remaining <= remaining - R_ONE;
        if (remaining == R_ONE) state <= IDLE;
      end
    end
  end

  assign busy = state == STEP;
endmodule

// File: tb/tb_mario_horizontal_mover.sv
// tb_mario_horizontal_mover: random and directed stimulus against a per-frame path model
module tb_mario_horizontal_mover;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0, left = 1'b0, right = 1'b0;
  logic [7:0] bg [12][17];
  logic signed [31:0] y = 0;
  logic signed [31:0] mario_x;
  logic signed [3:0] velocity;
  logic facing_left, busy, blocked;
  int checks = 0, failures = 0;

  mario_horizontal_mover dut (
    .movement_clock(clk), .reset(reset), .tick(tick), .left(left), .right(right),
    .background(bg), .mario_y(y), .mario_x(mario_x), .velocity(velocity),
    .facing_left(facing_left), .busy(busy), .blocked(blocked)
  );

  always #5 clk = ~clk;

  typedef struct {int x; bit coll;} step_t;
  step_t q[$];
  int mx = 100, mv = 0, mcount = 0, mprev = 0;
  bit mfl = 0, mblk = 0, pend = 0;

  task automatic chk(string nm, int act, int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit hits(int nx, int d);
    int col, rt, rb;
    if (nx < 0 || nx + 42 > 640) return 1;
    col = d > 0 ? (nx + 41) / 40 : nx / 40;
    rt = int'(y) / 40;
    rb = (int'(y) + 41) / 40;
    if (col >= 17) return 0;
    return (rt >= 0 && rt < 12 && bg[rt][col] == 8'd2) || (rb >= 0 && rb < 12 && bg[rb][col] == 8'd2);
  endfunction

  task automatic model_reset();
    mx = 100; mv = 0; mcount = 0; mprev = 0; mfl = 0; mblk = 0; pend = 0;
    q.delete();
  endtask

  // one call per clock edge: a serviced frame precomputes its whole pixel path
  task automatic model_step();
    int i, x, d;
    step_t e;
    i = (right && !left) ? 1 : (left && !right) ? -1 : 0;
    if (q.size() > 0) begin
      if (tick) pend = 1;
      e = q.pop_front();
      if (e.coll) begin mv = 0; mcount = 0; mblk = 1; end
      else mx = e.x;
    end else if (tick || pend) begin
      pend = 0; mblk = 0;
      if (i != mprev) mcount = 0;
      if (mcount == 0) mv += int'(i * 4 > mv) - int'(i * 4 < mv);
      mcount = (mcount + 1) % 4;
      mprev = i;
      if (i != 0) mfl = i < 0;
      d = mv > 0 ? 1 : -1;
      x = mx;
      for (int k = 0; k < (mv < 0 ? -mv : mv); k++) begin
        if (hits(x + d, d)) begin
          e.x = x; e.coll = 1; q.push_back(e);
          break;
        end
        x += d;
        e.x = x; e.coll = 0; q.push_back(e);
      end
    end
  endtask

  always @(negedge clk) begin
    chk("mario_x", int'(mario_x), mx);
    chk("velocity", int'(velocity), mv);
    chk("facing_left", int'(facing_left), int'(mfl));
    chk("busy", int'(busy), int'(q.size() != 0));
    chk("blocked", int'(blocked), int'(mblk));
  end

  task automatic cycle();
    @(posedge clk);
    #1;
    if (reset) model_reset();
    else model_step();
  endtask

  task automatic do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    repeat (7) cycle();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    cycle();
    cycle();
    reset = 1'b0;
  endtask

  initial begin
    foreach (bg[r, c]) bg[r][c] = 8'd0;
    cycle();
    cycle();
    reset = 1'b0;
    chk("reset_x", int'(mario_x), 100);
    chk("reset_v", int'(velocity), 0);
    chk("reset_busy", int'(busy), 0);

    right = 1'b1;
    repeat (16) do_tick();
    chk("ramp_x", int'(mario_x), 140);
    chk("ramp_v", int'(velocity), 4);
    right = 1'b0;
    repeat (16) do_tick();
    chk("coast_x", int'(mario_x), 164);
    chk("coast_v", int'(velocity), 0);

    do_reset();
    y = 80;
    bg[2][5] = 8'd2;
    right = 1'b1;
    repeat (21) do_tick();
    chk("tile_x", int'(mario_x), 158);
    chk("tile_v", int'(velocity), 0);
    chk("tile_blocked", int'(blocked), 1);
    do_tick();
    chk("tile_again_x", int'(mario_x), 158);
    chk("tile_again_blocked", int'(blocked), 1);

    do_reset();
    bg[2][5] = 8'd0;
    y = 0;
    repeat (5) do_tick();
    chk("rev_start_v", int'(velocity), 2);
    right = 1'b0;
    left = 1'b1;
    do_tick();
    chk("rev_v1", int'(velocity), 1);
    chk("rev_face", int'(facing_left), 1);
    repeat (4) do_tick();
    chk("rev_v0", int'(velocity), 0);
    repeat (4) do_tick();
    chk("rev_vm1", int'(velocity), -1);
    repeat (60) do_tick();
    chk("left_wall_x", int'(mario_x), 0);
    chk("left_wall_blocked", int'(blocked), 1);
    left = 1'b0;
    right = 1'b1;
    repeat (180) do_tick();
    chk("right_wall_x", int'(mario_x), 598);
    chk("right_wall_blocked", int'(blocked), 1);

    do_reset();
    repeat (12) do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
    cycle();
    chk("mid_step_busy", int'(busy), 1);
    #1 reset = 1'b1;
    model_reset();
    #1;
    chk("async_reset_x", int'(mario_x), 100);
    chk("async_reset_v", int'(velocity), 0);
    cycle();
    reset = 1'b0;
    repeat (12) do_tick();
    tick = 1'b1;
    cycle();
    tick = 1'b0;
    cycle();
    tick = 1'b1;
    cycle();
    cycle();
    tick = 1'b0;
    repeat (10) cycle();
    chk("pending_x", int'(mario_x), 132);
    chk("pending_busy", int'(busy), 0);

    do_reset();
    for (int n = 0; n < 4000; n++) begin
      if (reset) reset = 1'b0;
      else if ($urandom_range(0, 799) == 0) begin reset = 1'b1; model_reset(); end
      if ($urandom_range(0, 15) == 0) left = ~left;
      if ($urandom_range(0, 15) == 0) right = ~right;
      tick = $urandom_range(0, 5) == 0;
      if (q.size() == 0 && $urandom_range(0, 39) == 0) y = $urandom_range(0, 520);
      if (q.size() == 0 && $urandom_range(0, 19) == 0)
        bg[$urandom_range(0, 11)][$urandom_range(0, 16)] = $urandom_range(0, 1) ? 8'd2 : 8'd0;
      cycle();
    end
    tick = 1'b0;
    repeat (8) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
